// File: rtl/cache_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// cache_port_arbiter_if
//   Bundles every signal between the two requesters, the arbiter and the
//   CPU-side word port of the cache.
//
//   Requester side (per port N = 0,1)
//     pN_rd_req / pN_wr_req  request, held by the requester until pN_done
//     pN_addr / pN_wr_data   byte address and write word of the request
//     pN_done                one-cycle completion pulse
//     pN_rd_data             read word, non-zero only while pN_done on a read
//     pN_grant_cnt           accesses granted to port N (wraps)
//     pN_stall_cnt           miss cycles seen while port N owned the cache (wraps)
//   Cache side
//     c_addr / c_wr_data     address and write word to the cache
//     c_rd_req / c_wr_req    access strobes to the cache
//     c_miss / c_rd_data     miss indication and registered read word
//
//   Handshake: a requester raises rd_req or wr_req with addr/wr_data and keeps
//   the request up until the cycle in which pN_done is high; it drops or changes
//   it on the clock edge that ends that cycle. A request still high in the next
//   idle cycle is a new access. The cache completes an access on the first edge
//   where c_miss is low while a strobe is asserted.
//
//   Modports: slave = the arbiter, master = requesters plus cache model.
// ---------------------------------------------------------------------------
interface cache_port_arbiter_if #(
    parameter int CNT_W = 32
);
    logic             p0_rd_req;
    logic             p0_wr_req;
    logic [31:0]      p0_addr;
    logic [31:0]      p0_wr_data;
    logic             p0_done;
    logic [31:0]      p0_rd_data;
    logic [CNT_W-1:0] p0_grant_cnt;
    logic [CNT_W-1:0] p0_stall_cnt;

    logic             p1_rd_req;
    logic             p1_wr_req;
    logic [31:0]      p1_addr;
    logic [31:0]      p1_wr_data;
    logic             p1_done;
    logic [31:0]      p1_rd_data;
    logic [CNT_W-1:0] p1_grant_cnt;
    logic [CNT_W-1:0] p1_stall_cnt;

    logic [31:0]      c_addr;
    logic             c_rd_req;
    logic             c_wr_req;
    logic [31:0]      c_wr_data;
    logic             c_miss;
    logic [31:0]      c_rd_data;

    modport slave (
        input  p0_rd_req, p0_wr_req, p0_addr, p0_wr_data,
        input  p1_rd_req, p1_wr_req, p1_addr, p1_wr_data,
        input  c_miss, c_rd_data,
        output p0_done, p0_rd_data, p0_grant_cnt, p0_stall_cnt,
        output p1_done, p1_rd_data, p1_grant_cnt, p1_stall_cnt,
        output c_addr, c_rd_req, c_wr_req, c_wr_data
    );

    modport master (
        output p0_rd_req, p0_wr_req, p0_addr, p0_wr_data,
        output p1_rd_req, p1_wr_req, p1_addr, p1_wr_data,
        output c_miss, c_rd_data,
        input  p0_done, p0_rd_data, p0_grant_cnt, p0_stall_cnt,
        input  p1_done, p1_rd_data, p1_grant_cnt, p1_stall_cnt,
        input  c_addr, c_rd_req, c_wr_req, c_wr_data
    );
endinterface

// File: rtl/cache_port_arbiter.sv
// ---------------------------------------------------------------------------
// cache_port_arbiter
//   Shares the single CPU-side word port of the cache between two requesters.
//   One access is in flight at a time: it is granted in IDLE, presented to the
//   cache in BUSY until the cache reports a hit (c_miss low), and completed with
//   a one-cycle done pulse in RESP. Ties go round-robin (ROUND_ROBIN=1) or to
//   port 0 (ROUND_ROBIN=0). Per-port grant and stall counters wrap.
//
//   Ports
//     clk          clock
//     rst          synchronous active-high reset
//     bus          requester/cache signal bundle (slave side)
//     o_dbg_state  current FSM state: 0=IDLE, 1=BUSY, 2=RESP
// ---------------------------------------------------------------------------
module cache_port_arbiter #(
    parameter bit ROUND_ROBIN = 1'b1,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    cache_port_arbiter_if.slave  bus,
    output logic [1:0]           o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic             r_owner;
    logic             r_op_read;
    logic [31:0]      r_addr;
    logic [31:0]      r_wr_data;
    logic             r_last_grant;
    logic [CNT_W-1:0] r_grant_cnt [2];
    logic [CNT_W-1:0] r_stall_cnt [2];

    logic [1:0]       w_rd_req;
    logic [1:0]       w_wr_req;
    logic [1:0]       w_req;
    logic [31:0]      w_addr    [2];
    logic [31:0]      w_wr_data [2];
    logic             w_grant_port;
    logic             w_grant;

    assign w_rd_req     = {bus.p1_rd_req, bus.p0_rd_req};
    assign w_wr_req     = {bus.p1_wr_req, bus.p0_wr_req};
    assign w_req        = w_rd_req | w_wr_req;
    assign w_addr[0]    = bus.p0_addr;
    assign w_addr[1]    = bus.p1_addr;
    assign w_wr_data[0] = bus.p0_wr_data;
    assign w_wr_data[1] = bus.p1_wr_data;

    // Winner among the current requesters. On a tie the round-robin variant
    // picks the port that did not win last; r_last_grant resets to 1 so that
    // port 0 wins the first tie.
    always_comb begin
        w_grant_port = 1'b0;
        if (w_req == 2'b11) begin
            w_grant_port = ROUND_ROBIN ? ~r_last_grant : 1'b0;
        end else if (w_req[1]) begin
            w_grant_port = 1'b1;
        end
    end

    assign w_grant = (r_state == S_IDLE) && (w_req != 2'b00);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_req != 2'b00) w_next_state = S_BUSY;
            S_BUSY:  if (!bus.c_miss)    w_next_state = S_RESP;
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ---------------- access latches and statistics ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner      <= 1'b0;
            r_op_read    <= 1'b0;
            r_addr       <= '0;
            r_wr_data    <= '0;
            r_last_grant <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                r_grant_cnt[i] <= '0;
                r_stall_cnt[i] <= '0;
            end
        end else begin
            if (w_grant) begin
                // Read wins when a port raises both strobes.
                r_owner      <= w_grant_port;
                r_op_read    <= w_rd_req[w_grant_port];
                r_addr       <= w_addr[w_grant_port];
                r_wr_data    <= w_wr_data[w_grant_port];
                r_last_grant <= w_grant_port;
                r_grant_cnt[w_grant_port] <= r_grant_cnt[w_grant_port] + CNT_W'(1);
            end
            if ((r_state == S_BUSY) && bus.c_miss) begin
                r_stall_cnt[r_owner] <= r_stall_cnt[r_owner] + CNT_W'(1);
            end
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.c_rd_req   = 1'b0;
        bus.c_wr_req   = 1'b0;
        bus.p0_done    = 1'b0;
        bus.p1_done    = 1'b0;
        bus.p0_rd_data = '0;
        bus.p1_rd_data = '0;
        case (r_state)
            S_BUSY: begin
                bus.c_rd_req = r_op_read;
                bus.c_wr_req = ~r_op_read;
            end
            S_RESP: begin
                // The cache registered the read word on the hit edge, so it is
                // passed straight through during the done cycle.
                if (r_owner) begin
                    bus.p1_done = 1'b1;
                    if (r_op_read) bus.p1_rd_data = bus.c_rd_data;
                end else begin
                    bus.p0_done = 1'b1;
                    if (r_op_read) bus.p0_rd_data = bus.c_rd_data;
                end
            end
            default: ;
        endcase
    end

    // Latches are driven continuously; they only change on a grant edge, which
    // keeps the address and write word stable for the whole of BUSY.
    assign bus.c_addr       = r_addr;
    assign bus.c_wr_data    = r_wr_data;
    assign bus.p0_grant_cnt = r_grant_cnt[0];
    assign bus.p1_grant_cnt = r_grant_cnt[1];
    assign bus.p0_stall_cnt = r_stall_cnt[0];
    assign bus.p1_stall_cnt = r_stall_cnt[1];
    assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_port_arbiter
//   dut_a: round-robin, 32-bit counters, driven from per-port request tables
//          and checked against a transaction-level model.
//   dut_b: fixed priority, 4-bit counters, for the priority and wrap cases.
// ---------------------------------------------------------------------------
module tb_cache_port_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_port_arbiter_if #(.CNT_W(32)) bus_a ();
  cache_port_arbiter_if #(.CNT_W(4))  bus_b ();
  logic [1:0] dbg_a;
  logic [1:0] dbg_b;

  cache_port_arbiter #(.ROUND_ROBIN(1'b1), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a), .o_dbg_state(dbg_a)
  );
  cache_port_arbiter #(.ROUND_ROBIN(1'b0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b), .o_dbg_state(dbg_b)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  // ---------------- request tables and reference model ----------------
  logic        rq_rd   [2];
  logic        rq_wr   [2];
  logic [31:0] rq_addr [2];
  logic [31:0] rq_data [2];

  logic        m_last;
  logic [31:0] m_grant [2];
  logic [31:0] m_stall [2];
  logic [0:0]  exp_q [$];

  // Round-robin rule: a lone requester wins; on a tie the port that did not
  // win last time wins.
  function automatic logic model_pick();
    logic r0;
    logic r1;
    r0 = rq_rd[0] | rq_wr[0];
    r1 = rq_rd[1] | rq_wr[1];
    if (r0 && r1) return ~m_last;
    return r1;
  endfunction

  function automatic logic get_done(input logic p);
    return p ? bus_a.p1_done : bus_a.p0_done;
  endfunction
  function automatic logic [31:0] get_rd(input logic p);
    return p ? bus_a.p1_rd_data : bus_a.p0_rd_data;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_reqs();
    bus_a.p0_rd_req  = rq_rd[0];
    bus_a.p0_wr_req  = rq_wr[0];
    bus_a.p0_addr    = rq_addr[0];
    bus_a.p0_wr_data = rq_data[0];
    bus_a.p1_rd_req  = rq_rd[1];
    bus_a.p1_wr_req  = rq_wr[1];
    bus_a.p1_addr    = rq_addr[1];
    bus_a.p1_wr_data = rq_data[1];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int p = 0; p < 2; p++) begin
      rq_rd[p] = 1'b0; rq_wr[p] = 1'b0; rq_addr[p] = '0; rq_data[p] = '0;
      m_grant[p] = '0; m_stall[p] = '0;
    end
    m_last = 1'b1;
    drive_reqs();
    bus_a.c_miss = 1'b0; bus_a.c_rd_data = '0;
    bus_b.p0_rd_req = 1'b0; bus_b.p0_wr_req = 1'b0; bus_b.p0_addr = '0; bus_b.p0_wr_data = '0;
    bus_b.p1_rd_req = 1'b0; bus_b.p1_wr_req = 1'b0; bus_b.p1_addr = '0; bus_b.p1_wr_data = '0;
    bus_b.c_miss = 1'b0; bus_b.c_rd_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One complete access on dut_a. Starts at a negedge in IDLE with the
  // request(s) already driven and ends at the negedge of the following IDLE.
  task automatic run_access(input int misses, input logic [31:0] rdata,
                            input bit rereq, input bit scramble);
    logic        own;
    logic        e_read;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    logic [0:0]  e_own;
    own    = model_pick();
    exp_q.push_back(own);
    e_read = rq_rd[own];
    e_addr = rq_addr[own];
    e_data = rq_data[own];
    bus_a.c_rd_data = rdata;
    bus_a.c_miss    = 1'b0;
    @(negedge clk);
    total_cnt++; if ({bus_a.c_rd_req, bus_a.c_wr_req} !== {e_read, ~e_read}) $display("FAIL busy_strobes: got %b want %b", {bus_a.c_rd_req, bus_a.c_wr_req}, {e_read, ~e_read}); else pass_cnt++;
    total_cnt++; if (bus_a.c_addr !== e_addr) $display("FAIL busy_addr: got %h want %h", bus_a.c_addr, e_addr); else pass_cnt++;
    total_cnt++; if (bus_a.c_wr_data !== e_data) $display("FAIL busy_wr_data: got %h want %h", bus_a.c_wr_data, e_data); else pass_cnt++;
    total_cnt++; if ({bus_a.p1_done, bus_a.p0_done} !== 2'b00) $display("FAIL busy_done: got %b want 00", {bus_a.p1_done, bus_a.p0_done}); else pass_cnt++;
    bus_a.c_miss = (misses > 0);
    for (int k = 1; k <= misses; k++) begin
      if (scramble) begin
        rq_addr[own] = ~e_addr; rq_data[own] = ~e_data; drive_reqs();
      end
      @(negedge clk);
      total_cnt++; if ({bus_a.c_rd_req, bus_a.c_wr_req} !== {e_read, ~e_read}) $display("FAIL miss_strobes: got %b want %b at miss %0d", {bus_a.c_rd_req, bus_a.c_wr_req}, {e_read, ~e_read}, k); else pass_cnt++;
      total_cnt++; if ({bus_a.c_addr, bus_a.c_wr_data} !== {e_addr, e_data}) $display("FAIL miss_latched: got %h want %h", {bus_a.c_addr, bus_a.c_wr_data}, {e_addr, e_data}); else pass_cnt++;
      total_cnt++; if ((own ? bus_a.p1_stall_cnt : bus_a.p0_stall_cnt) !== m_stall[own] + 32'(k)) $display("FAIL stall_cnt: got %0d want %0d", own ? bus_a.p1_stall_cnt : bus_a.p0_stall_cnt, m_stall[own] + 32'(k)); else pass_cnt++;
      bus_a.c_miss = (k < misses);
    end
    @(negedge clk);
    e_own = exp_q.pop_front();
    total_cnt++; if ({bus_a.p1_done, bus_a.p0_done} !== (e_own[0] ? 2'b10 : 2'b01)) $display("FAIL resp_done: got %b want %b", {bus_a.p1_done, bus_a.p0_done}, e_own[0] ? 2'b10 : 2'b01); else pass_cnt++;
    total_cnt++; if (get_rd(own) !== (e_read ? rdata : 32'h0)) $display("FAIL resp_rd_data: got %h want %h", get_rd(own), e_read ? rdata : 32'h0); else pass_cnt++;
    total_cnt++; if (get_rd(~own) !== 32'h0) $display("FAIL resp_other_rd_data: got %h want 0", get_rd(~own)); else pass_cnt++;
    total_cnt++; if ({bus_a.c_rd_req, bus_a.c_wr_req} !== 2'b00) $display("FAIL resp_strobes: got %b want 00", {bus_a.c_rd_req, bus_a.c_wr_req}); else pass_cnt++;
    m_grant[own] = m_grant[own] + 1;
    m_stall[own] = m_stall[own] + 32'(misses);
    m_last       = own;
    if (rereq) begin
      rq_addr[own] = e_addr; rq_data[own] = e_data;
    end else begin
      rq_rd[own] = 1'b0; rq_wr[own] = 1'b0;
    end
    drive_reqs();
    bus_a.c_rd_data = $urandom;
    @(negedge clk);
    total_cnt++; if ({bus_a.p1_done, bus_a.p0_done, get_rd(1'b0), get_rd(1'b1)} !== 66'h0) $display("FAIL idle_outputs: done=%b rd0=%h rd1=%h want zeros", {bus_a.p1_done, bus_a.p0_done}, get_rd(1'b0), get_rd(1'b1)); else pass_cnt++;
    total_cnt++; if ({bus_a.p0_grant_cnt, bus_a.p1_grant_cnt} !== {m_grant[0], m_grant[1]}) $display("FAIL grant_cnt: got %0d/%0d want %0d/%0d", bus_a.p0_grant_cnt, bus_a.p1_grant_cnt, m_grant[0], m_grant[1]); else pass_cnt++;
    total_cnt++; if ({bus_a.p0_stall_cnt, bus_a.p1_stall_cnt} !== {m_stall[0], m_stall[1]}) $display("FAIL stall_totals: got %0d/%0d want %0d/%0d", bus_a.p0_stall_cnt, bus_a.p1_stall_cnt, m_stall[0], m_stall[1]); else pass_cnt++;
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    do_reset();
    total_cnt++; if ({bus_a.c_rd_req, bus_a.c_wr_req, bus_a.p0_done, bus_a.p1_done} !== 4'b0) $display("FAIL reset_strobes: got %b want 0000", {bus_a.c_rd_req, bus_a.c_wr_req, bus_a.p0_done, bus_a.p1_done}); else pass_cnt++;
    total_cnt++; if ({bus_a.c_addr, bus_a.c_wr_data, bus_a.p0_rd_data, bus_a.p1_rd_data} !== 128'h0) $display("FAIL reset_data: addr=%h wd=%h want 0", bus_a.c_addr, bus_a.c_wr_data); else pass_cnt++;
    total_cnt++; if ({bus_a.p0_grant_cnt, bus_a.p1_grant_cnt, bus_a.p0_stall_cnt, bus_a.p1_stall_cnt} !== 128'h0) $display("FAIL reset_counters: got nonzero want 0"); else pass_cnt++;
    total_cnt++; if ({dbg_a, dbg_b} !== 4'b0) $display("FAIL reset_state: got %b want 0000", {dbg_a, dbg_b}); else pass_cnt++;
  endtask

  task automatic test_reset_mid_busy();
    rq_rd[0] = 1'b1; rq_addr[0] = 32'h100; drive_reqs();
    @(negedge clk);
    total_cnt++; if (bus_a.c_rd_req !== 1'b1) $display("FAIL pre_reset_busy: got %b want 1", bus_a.c_rd_req); else pass_cnt++;
    bus_a.c_miss = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    rq_rd[0] = 1'b0; drive_reqs();
    @(negedge clk);
    total_cnt++; if ({bus_a.c_rd_req, bus_a.c_wr_req, bus_a.p0_done} !== 3'b0) $display("FAIL reset_busy_strobes: got %b want 000", {bus_a.c_rd_req, bus_a.c_wr_req, bus_a.p0_done}); else pass_cnt++;
    total_cnt++; if ({bus_a.p0_grant_cnt, bus_a.p0_stall_cnt} !== 64'h0) $display("FAIL reset_busy_counters: got %0d/%0d want 0/0", bus_a.p0_grant_cnt, bus_a.p0_stall_cnt); else pass_cnt++;
    total_cnt++; if (dbg_a !== 2'd0) $display("FAIL reset_busy_state: got %0d want 0", dbg_a); else pass_cnt++;
    rst = 1'b0; bus_a.c_miss = 1'b0;
    m_last = 1'b1; m_grant[0] = '0; m_grant[1] = '0; m_stall[0] = '0; m_stall[1] = '0;
    repeat (2) begin
      @(negedge clk);
      total_cnt++; if ({bus_a.p0_done, bus_a.c_rd_req} !== 2'b00) $display("FAIL post_reset_quiet: got %b want 00", {bus_a.p0_done, bus_a.c_rd_req}); else pass_cnt++;
    end
  endtask

  task automatic test_read_hit();
    rq_rd[0] = 1'b1; rq_addr[0] = 32'h40; rq_data[0] = 32'h0; drive_reqs();
    run_access(0, 32'hDEADBEEF, 1'b0, 1'b0);
    total_cnt++; if ({bus_a.p0_grant_cnt, bus_a.p0_stall_cnt} !== {32'd1, 32'd0}) $display("FAIL t2_counters: got %0d/%0d want 1/0", bus_a.p0_grant_cnt, bus_a.p0_stall_cnt); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    do_reset();
    rq_rd[0] = 1'b1; rq_addr[0] = 32'h200; rq_data[0] = $urandom;
    rq_rd[1] = 1'b1; rq_addr[1] = 32'h300; rq_data[1] = $urandom;
    drive_reqs();
    run_access(0, $urandom, 1'b1, 1'b0);
    run_access(1, $urandom, 1'b1, 1'b0);
    run_access(0, $urandom, 1'b0, 1'b0);
    run_access(2, $urandom, 1'b0, 1'b0);
    total_cnt++; if ({bus_a.p0_grant_cnt, bus_a.p1_grant_cnt} !== {32'd2, 32'd2}) $display("FAIL rr_balance: got %0d/%0d want 2/2", bus_a.p0_grant_cnt, bus_a.p1_grant_cnt); else pass_cnt++;
  endtask

  task automatic test_write_miss();
    rq_wr[1] = 1'b1; rq_addr[1] = 32'h80; rq_data[1] = 32'h1234; drive_reqs();
    run_access(12, $urandom, 1'b0, 1'b1);
  endtask

  task automatic test_rd_wr_both();
    rq_rd[0] = 1'b1; rq_wr[0] = 1'b1; rq_addr[0] = $urandom; rq_data[0] = $urandom; drive_reqs();
    run_access(3, $urandom, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 30; it++) begin
      int pat;
      pat = $urandom_range(1, 3);
      for (int p = 0; p < 2; p++) begin
        if (pat[p]) begin
          rq_rd[p]   = 1'($urandom_range(0, 1));
          rq_wr[p]   = rq_rd[p] ? 1'($urandom_range(0, 1)) : 1'b1;
          rq_addr[p] = {p[0], 31'($urandom)};
          rq_data[p] = $urandom;
        end
      end
      drive_reqs();
      run_access($urandom_range(0, 3), $urandom, 1'b0, 1'($urandom_range(0, 1)));
      if (pat == 3) run_access($urandom_range(0, 3), $urandom, 1'b0, 1'b0);
    end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    bus_b.p0_rd_req = 1'b1; bus_b.p0_addr = 32'h500;
    bus_b.p1_rd_req = 1'b1; bus_b.p1_addr = 32'h600;
    bus_b.c_rd_data = 32'hCAFE0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total_cnt++; if (bus_b.c_addr !== 32'h500) $display("FAIL fp_addr: got %h want 500 (access %0d)", bus_b.c_addr, i); else pass_cnt++;
      @(negedge clk);
      total_cnt++; if ({bus_b.p1_done, bus_b.p0_done} !== 2'b01) $display("FAIL fp_done_order: got %b want 01 (access %0d)", {bus_b.p1_done, bus_b.p0_done}, i); else pass_cnt++;
      if (i == 2) bus_b.p0_rd_req = 1'b0;
      @(negedge clk);
    end
    @(negedge clk);
    total_cnt++; if (bus_b.c_addr !== 32'h600) $display("FAIL fp_p1_addr: got %h want 600", bus_b.c_addr); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if ({bus_b.p1_done, bus_b.p1_rd_data} !== {1'b1, 32'hCAFE0000}) $display("FAIL fp_p1_done: got %b/%h want 1/cafe0000", bus_b.p1_done, bus_b.p1_rd_data); else pass_cnt++;
    bus_b.p1_rd_req = 1'b0;
    @(negedge clk);
    total_cnt++; if ({bus_b.p0_grant_cnt, bus_b.p1_grant_cnt} !== {4'd3, 4'd1}) $display("FAIL fp_grants: got %0d/%0d want 3/1", bus_b.p0_grant_cnt, bus_b.p1_grant_cnt); else pass_cnt++;
  endtask

  task automatic test_stall_wrap();
    do_reset();
    bus_b.p0_rd_req = 1'b1; bus_b.p0_addr = 32'h700;
    @(negedge clk);
    bus_b.c_miss = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      total_cnt++; if (bus_b.p0_stall_cnt !== 4'(k)) $display("FAIL wrap_stall: got %0d want %0d after %0d misses", bus_b.p0_stall_cnt, 4'(k), k); else pass_cnt++;
      bus_b.c_miss = (k < 16);
    end
    @(negedge clk);
    total_cnt++; if (bus_b.p0_done !== 1'b1) $display("FAIL wrap_done: got %b want 1", bus_b.p0_done); else pass_cnt++;
    bus_b.p0_rd_req = 1'b0;
    @(negedge clk);
    total_cnt++; if ({bus_b.p0_stall_cnt, bus_b.p0_grant_cnt} !== {4'd0, 4'd1}) $display("FAIL wrap_final: got %0d/%0d want 0/1", bus_b.p0_stall_cnt, bus_b.p0_grant_cnt); else pass_cnt++;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_reset_mid_busy();
    test_read_hit();
    test_round_robin();
    test_write_miss();
    test_rd_wr_both();
    test_random();
    test_fixed_priority();
    test_stall_wrap();
    total_cnt++; if (exp_q.size() !== 0) $display("FAIL scoreboard_leftover: got %0d want 0", exp_q.size()); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
